cap_sensor_scanner: RTL and testbench

//  Time-multiplexed scheduler for N capacitive vehicle-presence pads at the intersection.

---
 rtl/cap_scan_pkg.sv | 19 +
 rtl/cap_sensor_debounce.sv | 57 +++++
 rtl/cap_sensor_scanner.sv | 198 +++++++++++++++++++
 tb/tb_cap_sensor_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cap_scan_pkg.sv
// Shared types and constants for the capacitive pad scanner.
package cap_scan_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_CHARGE    = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_DISCHARGE = 3'd4
    } state_e;

    // Width of a pad index; a single pad still needs one bit to stay legal.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cap_sensor_debounce.sv
// Per-pad debouncer: a stable bit flips only after DEBOUNCE consecutive
// samples that agree with each other and disagree with the stable bit.
module cap_sensor_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic sampleValid,
    input  logic rawSample,
    output logic state,
    output logic rise
);

    logic [3:0] run_q;
    logic [3:0] run_d;
    logic       state_q;
    logic       state_d;
    logic       rise_q;
    logic       rise_d;

    // Next run length, stable bit and rise pulse from the current sample.
    always_comb begin
        run_d   = run_q;
        state_d = state_q;
        rise_d  = 1'b0;
        if (sampleValid) begin
            if (rawSample == state_q) begin
                run_d = 4'd0;
            end else if (({1'b0, run_q} + 5'd1) >= 5'(DEBOUNCE)) begin
                state_d = rawSample;
                run_d   = 4'd0;
                rise_d  = rawSample;
            end else begin
                run_d = run_q + 4'd1;
            end
        end else begin
            run_d = run_q;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q   <= 4'd0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            state_q <= state_d;
            rise_q  <= rise_d;
        end
    end

    assign state = state_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cap_sensor_scanner.sv
// Round-robin charge/sample/discharge scheduler for capacitive presence pads.
// Only one pad is driven at a time; each pad's reading is debounced locally.
module cap_sensor_scanner
    import cap_scan_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       thresholdVal,
    input  logic [31:0]       delayVal,
    input  logic [N_CH-1:0]   channelMask,
    input  logic [N_CH-1:0]   sensorReceive,
    output logic [N_CH-1:0]   sensorSend,
    output logic [N_CH-1:0]   sensorState,
    output logic [N_CH-1:0]   sensorEvent,
    output logic              scanDone,
    output logic              busy
);

    localparam int IDX_W  = ch_idx_w(N_CH);
    // One extra bit so "one past the last pad" is representable.
    localparam int SRCH_W = IDX_W + 1;

    logic [N_CH-1:0]   recv_meta_q;
    logic [N_CH-1:0]   recv_sync_q;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  thr_q;
    logic [CNT_W-1:0]  thr_d;
    logic [CNT_W-1:0]  dly_q;
    logic [CNT_W-1:0]  dly_d;
    logic [IDX_W-1:0]  ch_q;
    logic [IDX_W-1:0]  ch_d;
    logic [SRCH_W-1:0] search_q;
    logic [SRCH_W-1:0] search_d;
    logic [N_CH-1:0]   send_q;
    logic [N_CH-1:0]   send_d;
    logic              done_q;
    logic              done_d;
    logic              busy_q;
    logic              busy_d;

    logic              found_s;
    logic [IDX_W-1:0]  next_ch_s;
    logic              sample_valid_s;

    // Two-flop synchroniser for the asynchronous pad return lines.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            recv_meta_q <= {N_CH{1'b0}};
            recv_sync_q <= {N_CH{1'b0}};
        end else begin
            recv_meta_q <= sensorReceive;
            recv_sync_q <= recv_meta_q;
        end
    end

    // Priority search: lowest masked pad at or above the search index.
    always_comb begin
        found_s   = 1'b0;
        next_ch_s = {IDX_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (channelMask[i] && (SRCH_W'(i) >= search_q)) begin
                found_s   = 1'b1;
                next_ch_s = IDX_W'(i);
            end else begin
                found_s   = found_s;
                next_ch_s = next_ch_s;
            end
        end
    end

    // Scan FSM with a shared charge/discharge counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        thr_d    = thr_q;
        dly_d    = dly_q;
        ch_d     = ch_q;
        search_d = search_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (|channelMask)) begin
                    state_d  = ST_SELECT;
                    search_d = {SRCH_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (!enable || (channelMask == {N_CH{1'b0}})) begin
                    // Stopping early is not a completed pass: no scanDone.
                    state_d = ST_IDLE;
                end else if (found_s) begin
                    state_d = ST_CHARGE;
                    ch_d    = next_ch_s;
                    thr_d   = thresholdVal;
                    dly_d   = delayVal;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    done_d   = 1'b1;
                    search_d = {SRCH_W{1'b0}};
                    state_d  = ST_SELECT;
                end
            end
            ST_CHARGE: begin
                if (cnt_q == thr_q) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_DISCHARGE;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_DISCHARGE: begin
                if (cnt_q == dly_q) begin
                    state_d  = ST_SELECT;
                    search_d = {1'b0, ch_q} + {{(SRCH_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the drive lines are registered.
    always_comb begin
        send_d = {N_CH{1'b0}};
        if ((state_d == ST_CHARGE) || (state_d == ST_SAMPLE)) begin
            for (int i = 0; i < N_CH; i++) begin
                send_d[i] = (ch_d == IDX_W'(i));
            end
        end else begin
            send_d = {N_CH{1'b0}};
        end
        busy_d = (state_d != ST_IDLE);
    end

    // FSM, counter, latched configuration and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            thr_q    <= {CNT_W{1'b0}};
            dly_q    <= {CNT_W{1'b0}};
            ch_q     <= {IDX_W{1'b0}};
            search_q <= {SRCH_W{1'b0}};
            send_q   <= {N_CH{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            dly_q    <= dly_d;
            ch_q     <= ch_d;
            search_q <= search_d;
            send_q   <= send_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign sample_valid_s = (state_q == ST_SAMPLE);

    // A pad reads as occupied when its return line is pulled low.
    for (genvar g = 0; g < N_CH; g++) begin : g_pad
        cap_sensor_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clock       (clock),
            .reset       (reset),
            .sampleValid (sample_valid_s && (ch_q == IDX_W'(g))),
            .rawSample   (~recv_sync_q[g]),
            .state       (sensorState[g]),
            .rise        (sensorEvent[g])
        );
    end

    assign sensorSend = send_q;
    assign scanDone   = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// Directed self-checking bench for cap_sensor_scanner (N_CH=4, DEBOUNCE=3).
module tb_cap_sensor_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] thr;
    logic [31:0] dly;
    logic [3:0]  mask;
    logic [3:0]  rx;
    logic [3:0]  send;
    logic [3:0]  st;
    logic [3:0]  ev;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt [4];

    cap_sensor_scanner #(.N_CH(4), .DEBOUNCE(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .thresholdVal  (thr),
        .delayVal      (dly),
        .channelMask   (mask),
        .sensorReceive (rx),
        .sensorSend    (send),
        .sensorState   (st),
        .sensorEvent   (ev),
        .scanDone      (done),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Advance to the next scanDone pulse, tallying event pulses on the way.
    task automatic wait_done();
        bit seen = 1'b0;
        int t = 0;
        while (!seen && t < 200) begin
            @(negedge clock);
            t++;
            for (int b = 0; b < 4; b++) if (ev[b]) ev_cnt[b]++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_done: scanDone not seen within %0d cycles", t);
        end
    endtask

    task automatic clear_ev();
        for (int b = 0; b < 4; b++) ev_cnt[b] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; thr = 32'd3; dly = 32'd2;
        mask = 4'b1111; rx = 4'b1111;
        repeat (3) @(negedge clock);
        n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL reset_send: got %b want 0000", send); end
        n_cmp++; if (st !== 4'b0000) begin n_bad++; $display("FAIL reset_state: got %b want 0000", st); end
        n_cmp++; if (ev !== 4'b0000) begin n_bad++; $display("FAIL reset_event: got %b want 0000", ev); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    // Full mask, thr=3 dly=2: 9 cycles per pad, scanDone every 37 cycles.
    task automatic test_round_robin();
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_send;
        logic       exp_done;
        int pos;
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            exp_send = 4'b0000; exp_done = 1'b0;
            if (k >= 2) begin
                pos = (k - 2) % 37;
                if (pos < 36 && (pos % 9) < 5) exp_send = one << (pos / 9);
                exp_done = (pos == 36);
            end
            n_cmp++; if (send !== exp_send) begin n_bad++; $display("FAIL rr_send k=%0d: got %b want %b", k, send, exp_send); end
            n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL rr_done k=%0d: got %b want %b", k, done, exp_done); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy k=%0d: got %b want 1", k, busy); end
        end
    endtask

    // Pad 2 held occupied: rises on its 3rd sample with a single event.
    task automatic test_debounce_assert();
        wait_done();
        clear_ev();
        rx[2] = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            wait_done();
            n_cmp++;
            if (st !== ((p == 3) ? 4'b0100 : 4'b0000)) begin
                n_bad++; $display("FAIL assert_state pass=%0d: got %b want %b", p, st, (p == 3) ? 4'b0100 : 4'b0000);
            end
        end
        n_cmp++; if (ev_cnt[2] !== 1) begin n_bad++; $display("FAIL assert_events: got %0d want 1", ev_cnt[2]); end
        n_cmp++; if (ev_cnt[0] + ev_cnt[1] + ev_cnt[3] !== 0) begin n_bad++; $display("FAIL assert_other_events: got %0d want 0", ev_cnt[0] + ev_cnt[1] + ev_cnt[3]); end
    endtask

    // Pad 2 vacated: clears after 3 samples, with no event pulse.
    task automatic test_debounce_release();
        clear_ev();
        rx[2] = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            wait_done();
            n_cmp++;
            if (st[2] !== ((p < 3) ? 1'b1 : 1'b0)) begin
                n_bad++; $display("FAIL release_state pass=%0d: got %b want %b", p, st[2], (p < 3) ? 1'b1 : 1'b0);
            end
        end
        n_cmp++; if (ev_cnt[2] !== 0) begin n_bad++; $display("FAIL release_events: got %0d want 0", ev_cnt[2]); end
    endtask

    // Pad 1 samples 0,0,1,0,0: the agreeing sample must restart the run.
    task automatic test_glitch();
        logic [4:0] pat = 5'b00100;
        clear_ev();
        for (int p = 0; p < 5; p++) begin
            rx[1] = pat[p];
            wait_done();
            n_cmp++; if (st[1] !== 1'b0) begin n_bad++; $display("FAIL glitch_state pass=%0d: got %b want 0", p, st[1]); end
        end
        rx[1] = 1'b1;
        n_cmp++; if (ev_cnt[1] !== 0) begin n_bad++; $display("FAIL glitch_events: got %0d want 0", ev_cnt[1]); end
    endtask

    // Sparse mask with minimum timing, then empty mask back to IDLE.
    task automatic test_sparse_mask();
        logic [3:0] exp_send;
        int pos;
        mask = 4'b0101; thr = 32'd0; dly = 32'd0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            pos = (k - 1) % 9;
            exp_send = (pos <= 1) ? 4'b0001 : ((pos == 4 || pos == 5) ? 4'b0100 : 4'b0000);
            n_cmp++; if (send !== exp_send) begin n_bad++; $display("FAIL sparse_send k=%0d: got %b want %b", k, send, exp_send); end
            n_cmp++; if (done !== (pos == 8)) begin n_bad++; $display("FAIL sparse_done k=%0d: got %b want %b", k, done, pos == 8); end
        end
        mask = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy k=%0d: got %b want 0", k, busy); end
            n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL empty_send k=%0d: got %b want 0000", k, send); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done k=%0d: got %b want 0", k, done); end
        end
    endtask

    // Drop enable during pad-1 CHARGE; pad 1 completes, then IDLE; restart at pad 0.
    task automatic test_enable_drop();
        mask = 4'b1111; thr = 32'd3; dly = 32'd2;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drop_done k=%0d: got %b want 0", k, done); end
            if (k == 15) begin n_cmp++; if (send !== 4'b0010) begin n_bad++; $display("FAIL drop_pad1_sample: got %b want 0010", send); end end
            if (k == 16) begin n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL drop_pad1_discharge: got %b want 0000", send); end end
            if (k == 19) begin n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy_select: got %b want 1", busy); end end
            if (k == 20) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy_idle: got %b want 0", busy); end
                n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL drop_send_idle: got %b want 0000", send); end
            end
            if (k == 26) begin n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reen_busy: got %b want 1", busy); end end
            if (k == 27) begin n_cmp++; if (send !== 4'b0001) begin n_bad++; $display("FAIL reen_pad0: got %b want 0001", send); end end
            if (k == 12) enable = 1'b0;
            if (k == 25) enable = 1'b1;
        end
    endtask

    // Async reset between edges during pad-1 CHARGE clears everything at once.
    task automatic test_reset_mid_charge();
        int t = 0;
        wait_done();
        rx[0] = 1'b0;
        repeat (3) wait_done();
        n_cmp++; if (st !== 4'b0001) begin n_bad++; $display("FAIL pre_reset_state: got %b want 0001", st); end
        while (send !== 4'b0010 && t < 50) begin @(negedge clock); t++; end
        n_cmp++; if (send !== 4'b0010) begin n_bad++; $display("FAIL pre_reset_pad1: got %b want 0010", send); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL arst_send: got %b want 0000", send); end
        n_cmp++; if (st !== 4'b0000) begin n_bad++; $display("FAIL arst_state: got %b want 0000", st); end
        n_cmp++; if (ev !== 4'b0000) begin n_bad++; $display("FAIL arst_event: got %b want 0000", ev); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL arst_done: got %b want 0", done); end
        rx = 4'b1111;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        n_cmp++; if (send !== 4'b0000) begin n_bad++; $display("FAIL restart_select: got %b want 0000", send); end
        @(negedge clock);
        n_cmp++; if (send !== 4'b0001) begin n_bad++; $display("FAIL restart_pad0: got %b want 0001", send); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_debounce_assert();
        test_debounce_release();
        test_glitch();
        test_sparse_mask();
        test_enable_drop();
        test_reset_mid_charge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
